mul_share_arbiter_taint: RTL and testbench

Round-robin arbiter that shares one variable-latency taint-tracked multiplier between two requesters.
- Sits between two requester ports and a single `MUL` instance; the multiplier's latency depends on operand values.
- Issues at most one operation at a time, routes the result back tagged with the requester id, and aborts hung operations with a watchdog.
- Every data/control signal carries a 1-bit sticky taint shadow, propagated conservatively so that operand-dependent timing surfaces as taint on handshake outputs.

---
 rtl/mul_share_arbiter_taint.sv | 159 +++++++++++++++
 tb/tb_mul_share_arbiter_taint.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter_taint.sv
// rtl/mul_share_arbiter_taint.sv - round-robin share of one variable-latency multiplier with taint shadows
module mul_share_arbiter_taint #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic               req0_valid_t,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic               req0_a_t,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req0_b_t,
  input  logic               req1_valid,
  input  logic               req1_valid_t,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic               req1_a_t,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic               req1_b_t,
  output logic               req0_ready,
  output logic               req0_ready_t,
  output logic               req1_ready,
  output logic               req1_ready_t,
  output logic               mul_in_valid,
  output logic               mul_in_valid_t,
  output logic [WIDTH-1:0]   mul_in_a,
  output logic               mul_in_a_t,
  output logic [WIDTH-1:0]   mul_in_b,
  output logic               mul_in_b_t,
  input  logic               mul_out_valid,
  input  logic               mul_out_valid_t,
  input  logic [2*WIDTH-1:0] mul_out_result,
  input  logic               mul_out_result_t,
  output logic               rsp_valid,
  output logic               rsp_valid_t,
  output logic               rsp_id,
  output logic               rsp_id_t,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_result_t,
  output logic               rsp_err,
  output logic               rsp_err_t
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [3:0] WD_LIMIT = 4'(TIMEOUT);

  state_t     state_q;
  state_t     state_d;
  logic       rr_q;
  logic       id_q;
  logic       ctrl_t_q;
  logic [3:0] wd_q;
  logic       grant_any;
  logic       grant_id;
  logic       wd_hit;
  logic       valid_taint;

  assign valid_taint = req0_valid_t | req1_valid_t;
  // Compare the post-increment count so the decision lands on the TIMEOUT-th WAIT cycle.
  assign wd_hit      = (wd_q + 4'd1) == WD_LIMIT;

  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = rr_q;
    if (rr_q ? !req1_valid : !req0_valid) begin
      grant_id = ~rr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mul_out_valid || wd_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    mul_in_valid = 1'b0;
    if (!rst) begin
      if (state_q == IDLE && grant_any) begin
        req0_ready = !grant_id;
        req1_ready = grant_id;
      end
      mul_in_valid = (state_q == ISSUE);
    end
    req0_ready_t   = !rst && (ctrl_t_q | valid_taint);
    req1_ready_t   = !rst && (ctrl_t_q | valid_taint);
    mul_in_valid_t = ctrl_t_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= 1'b0;
      id_q         <= 1'b0;
      wd_q         <= '0;
      ctrl_t_q     <= 1'b0;
      mul_in_a     <= '0;
      mul_in_a_t   <= 1'b0;
      mul_in_b     <= '0;
      mul_in_b_t   <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_valid_t  <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_id_t     <= 1'b0;
      rsp_result   <= '0;
      rsp_result_t <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_err_t    <= 1'b0;
    end else begin
      rsp_valid    <= 1'b0;
      // Handshake taint: anything that can steer timing marks the response control.
      rsp_valid_t  <= rsp_valid_t | ctrl_t_q | mul_out_valid_t;
      rsp_id_t     <= rsp_id_t | ctrl_t_q | mul_out_valid_t;
      rsp_err_t    <= rsp_err_t | ctrl_t_q | mul_out_valid_t;
      rsp_result_t <= rsp_result_t | mul_out_result_t | mul_in_a_t | mul_in_b_t;
      case (state_q)
        IDLE: begin
          ctrl_t_q <= ctrl_t_q | valid_taint;
          if (grant_any) begin
            id_q       <= grant_id;
            mul_in_a   <= grant_id ? req1_a : req0_a;
            mul_in_b   <= grant_id ? req1_b : req0_b;
            mul_in_a_t <= mul_in_a_t | (grant_id ? req1_a_t : req0_a_t);
            mul_in_b_t <= mul_in_b_t | (grant_id ? req1_b_t : req0_b_t);
          end
        end
        ISSUE: wd_q <= '0;
        WAIT: begin
          ctrl_t_q <= ctrl_t_q | mul_out_valid_t;
          wd_q     <= wd_q + 4'd1;
          // A result arriving on the watchdog's last cycle still wins.
          if (mul_out_valid || wd_hit) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_err    <= !mul_out_valid;
            rsp_result <= mul_out_valid ? mul_out_result : '0;
            rr_q       <= ~id_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter_taint.sv
// tb/tb_mul_share_arbiter_taint.sv - randomized self-checking bench for mul_share_arbiter_taint
module tb_mul_share_arbiter_taint;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int RW      = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_valid_t, req0_a_t, req0_b_t;
  logic req1_valid, req1_valid_t, req1_a_t, req1_b_t;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic req0_ready, req0_ready_t, req1_ready, req1_ready_t;
  logic mul_in_valid, mul_in_valid_t, mul_in_a_t, mul_in_b_t;
  logic [WIDTH-1:0] mul_in_a, mul_in_b;
  logic mul_out_valid, mul_out_valid_t, mul_out_result_t;
  logic [RW-1:0] mul_out_result;
  logic rsp_valid, rsp_valid_t, rsp_id, rsp_id_t, rsp_result_t, rsp_err, rsp_err_t;
  logic [RW-1:0] rsp_result;

  mul_share_arbiter_taint #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_valid_t(req0_valid_t),
    .req0_a(req0_a), .req0_a_t(req0_a_t), .req0_b(req0_b), .req0_b_t(req0_b_t),
    .req1_valid(req1_valid), .req1_valid_t(req1_valid_t),
    .req1_a(req1_a), .req1_a_t(req1_a_t), .req1_b(req1_b), .req1_b_t(req1_b_t),
    .req0_ready(req0_ready), .req0_ready_t(req0_ready_t),
    .req1_ready(req1_ready), .req1_ready_t(req1_ready_t),
    .mul_in_valid(mul_in_valid), .mul_in_valid_t(mul_in_valid_t),
    .mul_in_a(mul_in_a), .mul_in_a_t(mul_in_a_t), .mul_in_b(mul_in_b), .mul_in_b_t(mul_in_b_t),
    .mul_out_valid(mul_out_valid), .mul_out_valid_t(mul_out_valid_t),
    .mul_out_result(mul_out_result), .mul_out_result_t(mul_out_result_t),
    .rsp_valid(rsp_valid), .rsp_valid_t(rsp_valid_t), .rsp_id(rsp_id), .rsp_id_t(rsp_id_t),
    .rsp_result(rsp_result), .rsp_result_t(rsp_result_t), .rsp_err(rsp_err), .rsp_err_t(rsp_err_t)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Multiplier model: mul_lat cycles after the start pulse, 0 means it never answers.
  int            mul_lat = 0;
  int            mul_rem = 0;
  int            arm_lat = 0;
  bit            mul_pend = 0;
  bit            taint_done = 0;
  logic [RW-1:0] mul_prod = '0;

  // Observations of the most recent cycle.
  int   issue_cyc, done_cyc, rsp_cyc, grant_cyc;
  int   n_rsp = 0, n_grant = 0, overlap = 0;
  bit   op_open = 0, pend_issue = 0;
  bit   s_r0, s_r1, s_miv, s_rv, taint_acc;
  bit   r_id, r_err;
  logic [RW-1:0] r_res;
  logic [63:0]   s_all;
  int   rr_m = 0;

  task automatic step();
    @(negedge clk);
    s_r0  = req0_ready;
    s_r1  = req1_ready;
    s_miv = mul_in_valid;
    s_rv  = rsp_valid;
    s_all = 64'({req0_ready, req0_ready_t, req1_ready, req1_ready_t, mul_in_valid, mul_in_valid_t,
                 mul_in_a, mul_in_a_t, mul_in_b, mul_in_b_t, rsp_valid, rsp_valid_t, rsp_id,
                 rsp_id_t, rsp_result, rsp_result_t, rsp_err, rsp_err_t});
    taint_acc = taint_acc | req0_ready_t | req1_ready_t | mul_in_valid_t | mul_in_a_t | mul_in_b_t
                | rsp_valid_t | rsp_id_t | rsp_result_t | rsp_err_t;
    if (rst) begin
      op_open = 0; pend_issue = 0; mul_pend = 0;
    end else begin
      if (rsp_valid) begin
        op_open = 0; n_rsp++; rsp_cyc = cyc;
        r_id = rsp_id; r_err = rsp_err; r_res = rsp_result;
      end
      if (req0_ready || req1_ready) begin
        if (op_open || (req0_ready && req1_ready)) overlap++;
        op_open = 1; pend_issue = 1; n_grant++; grant_cyc = cyc;
      end
      if (mul_in_valid) begin
        if (!pend_issue) overlap++;
        pend_issue = 0; issue_cyc = cyc;
        mul_pend = 1; mul_rem = mul_lat; arm_lat = mul_lat;
        mul_prod = RW'(mul_in_a) * RW'(mul_in_b);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    mul_out_valid = 0; mul_out_valid_t = 0; mul_out_result = RW'($urandom);
    if (mul_pend && arm_lat != 0) begin
      mul_rem--;
      if (mul_rem == 0) begin
        mul_out_valid = 1; mul_out_result = mul_prod; mul_out_valid_t = taint_done;
        taint_done = 0; mul_pend = 0; done_cyc = cyc;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; req0_valid = 0; req1_valid = 0;
    req0_valid_t = 0; req1_valid_t = 0; req0_a_t = 0; req0_b_t = 0; req1_a_t = 0; req1_b_t = 0;
    step(); step();
    rst = 0; rr_m = 0; taint_acc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (s_all !== 64'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", s_all); end
    step();
    n_checks++;
    if (s_all !== 64'd0) begin n_fail++; $display("FAIL reset_idle: got %h expected 0", s_all); end
  endtask

  task automatic test_single();
    int r0;
    do_reset();
    mul_lat = 2;
    req0_a = 4'd3; req0_b = 4'd5; req0_valid = 1;
    step();
    n_checks++;
    if (s_r0 !== 1'b1 || s_r1 !== 1'b0) begin
      n_fail++; $display("FAIL single_grant: got r0=%0d r1=%0d expected r0=1 r1=0", s_r0, s_r1);
    end
    req0_valid = 0; r0 = n_rsp;
    step();
    n_checks++;
    if (s_miv !== 1'b1) begin n_fail++; $display("FAIL single_issue: got %0d expected 1", s_miv); end
    for (int i = 0; i < 12; i++) step();
    n_checks++;
    if (n_rsp - r0 != 1) begin n_fail++; $display("FAIL single_rsp_count: got %0d expected 1", n_rsp - r0); end
    n_checks++;
    if (r_id !== 1'b0 || r_err !== 1'b0 || r_res !== 8'd15) begin
      n_fail++; $display("FAIL single_rsp: got id=%0d err=%0d res=%0d expected 0 0 15", r_id, r_err, r_res);
    end
    n_checks++;
    if (rsp_cyc - grant_cyc != 4) begin n_fail++; $display("FAIL single_latency: got %0d expected 4", rsp_cyc - grant_cyc); end
    n_checks++;
    if (taint_acc !== 1'b0) begin n_fail++; $display("FAIL single_taint: got %0d expected 0", taint_acc); end
  endtask

  task automatic test_contention();
    int g0, r0, grants, got, budget;
    bit exp_g, exp_r;
    do_reset();
    req0_a = 4'd2; req0_b = 4'd2; req1_a = 4'd1; req1_b = 4'd7;
    req0_valid = 1; req1_valid = 1;
    grants = 0; got = 0; budget = 200; exp_g = 0; exp_r = 0; overlap = 0;
    while (got < 4 && budget > 0) begin
      mul_lat = 1 + int'($urandom_range(0, TIMEOUT - 2));
      g0 = n_grant; r0 = n_rsp;
      step();
      budget--;
      if (n_rsp != r0) begin
        n_checks++;
        if (r_id !== exp_r || r_err !== 1'b0 || r_res !== (exp_r ? 8'd7 : 8'd4)) begin
          n_fail++; $display("FAIL contention_rsp%0d: got id=%0d err=%0d res=%0d expected id=%0d res=%0d",
                             got, r_id, r_err, r_res, exp_r, exp_r ? 7 : 4);
        end
        exp_r = ~exp_r; got++;
      end
      if (n_grant != g0 && grants < 4) begin
        n_checks++;
        if (s_r1 !== exp_g) begin n_fail++; $display("FAIL contention_grant%0d: got %0d expected %0d", grants, s_r1, exp_g); end
        exp_g = ~exp_g; grants++;
        if (grants == 4) begin req0_valid = 0; req1_valid = 0; end
      end
    end
    req0_valid = 0; req1_valid = 0;
    n_checks++;
    if (got != 4) begin n_fail++; $display("FAIL contention_timeout: got %0d responses expected 4", got); end
    n_checks++;
    if (overlap != 0) begin n_fail++; $display("FAIL contention_overlap: got %0d expected 0", overlap); end
  endtask

  task automatic test_timeout();
    int r0, budget;
    logic [WIDTH-1:0] a, b;
    do_reset();
    mul_lat = 0;
    req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_valid = 1;
    step();
    n_checks++;
    if (s_r1 !== 1'b1 || s_r0 !== 1'b0) begin n_fail++; $display("FAIL timeout_grant: got r0=%0d r1=%0d expected 0 1", s_r0, s_r1); end
    req1_valid = 0; r0 = n_rsp; budget = 40;
    while (n_rsp == r0 && budget > 0) begin step(); budget--; end
    n_checks++;
    if (n_rsp == r0) begin n_fail++; $display("FAIL timeout_wait: got no response expected 1"); end
    n_checks++;
    if (r_err !== 1'b1 || r_res !== '0 || r_id !== 1'b1) begin
      n_fail++; $display("FAIL timeout_rsp: got err=%0d res=%0d id=%0d expected 1 0 1", r_err, r_res, r_id);
    end
    n_checks++;
    if (rsp_cyc - issue_cyc != TIMEOUT + 1) begin
      n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", rsp_cyc - issue_cyc, TIMEOUT + 1);
    end
    mul_lat = 2;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    req0_a = a; req0_b = b; req1_a = WIDTH'($urandom);
    req0_valid = 1; req1_valid = 1;
    step();
    n_checks++;
    if (s_r0 !== 1'b1 || s_r1 !== 1'b0) begin n_fail++; $display("FAIL timeout_rr: got r0=%0d r1=%0d expected 1 0", s_r0, s_r1); end
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (r_err !== 1'b0 || r_res !== RW'(a) * RW'(b)) begin
      n_fail++; $display("FAIL timeout_next: got err=%0d res=%0d expected 0 %0d", r_err, r_res, RW'(a) * RW'(b));
    end
  endtask

  task automatic test_boundary();
    int r0, exp_lat;
    bit exp_err;
    logic [WIDTH-1:0] a, b;
    for (int lat = TIMEOUT - 1; lat <= TIMEOUT + 1; lat++) begin
      do_reset();
      mul_lat = lat;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      req0_a = a; req0_b = b; req0_valid = 1;
      step();
      req0_valid = 0; r0 = n_rsp;
      for (int i = 0; i < 25; i++) step();
      exp_err = (lat > TIMEOUT);
      exp_lat = exp_err ? TIMEOUT + 1 : lat + 1;
      n_checks++;
      if (n_rsp - r0 != 1) begin n_fail++; $display("FAIL bound%0d_count: got %0d expected 1", lat, n_rsp - r0); end
      n_checks++;
      if (r_err !== exp_err || r_res !== (exp_err ? RW'(0) : RW'(a) * RW'(b))) begin
        n_fail++; $display("FAIL bound%0d_rsp: got err=%0d res=%0d expected err=%0d res=%0d",
                           lat, r_err, r_res, exp_err, exp_err ? 0 : RW'(a) * RW'(b));
      end
      n_checks++;
      if (rsp_cyc - issue_cyc != exp_lat) begin
        n_fail++; $display("FAIL bound%0d_latency: got %0d expected %0d", lat, rsp_cyc - issue_cyc, exp_lat);
      end
    end
  endtask

  task automatic test_taint();
    do_reset();
    mul_lat = 2;
    req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_a_t = 1; req0_valid = 1;
    step();
    req0_valid = 0; req0_a_t = 0;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (mul_in_a_t !== 1'b1 || mul_in_b_t !== 1'b0 || rsp_result_t !== 1'b1) begin
      n_fail++; $display("FAIL taint_operand: got a_t=%0d b_t=%0d res_t=%0d expected 1 0 1", mul_in_a_t, mul_in_b_t, rsp_result_t);
    end
    n_checks++;
    if (rsp_valid_t !== 1'b0 || req0_ready_t !== 1'b0) begin
      n_fail++; $display("FAIL taint_ctrl_clean: got valid_t=%0d ready_t=%0d expected 0 0", rsp_valid_t, req0_ready_t);
    end
    taint_done = 1;
    req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_valid = 1;
    step();
    req1_valid = 0;
    for (int i = 0; i < 12; i++) step();
    n_checks++;
    if (rsp_valid_t !== 1'b1 || rsp_err_t !== 1'b1 || req0_ready_t !== 1'b1 || req1_ready_t !== 1'b1 || mul_in_valid_t !== 1'b1) begin
      n_fail++; $display("FAIL taint_sticky: got rv_t=%0d re_t=%0d r0_t=%0d r1_t=%0d miv_t=%0d expected all 1",
                         rsp_valid_t, rsp_err_t, req0_ready_t, req1_ready_t, mul_in_valid_t);
    end
    do_reset();
    n_checks++;
    if (s_all !== 64'd0) begin n_fail++; $display("FAIL taint_reset: got %h expected 0", s_all); end
  endtask

  task automatic test_reset_wait();
    int r0;
    logic [WIDTH-1:0] a;
    do_reset();
    mul_lat = 0;
    a = WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
    req0_a = a; req0_b = WIDTH'($urandom_range(1, (1 << WIDTH) - 1)); req0_a_t = 1; req0_valid = 1;
    step();
    req0_valid = 0; req0_a_t = 0;
    step(); step(); step();
    n_checks++;
    if (mul_in_a !== a) begin n_fail++; $display("FAIL rstwait_latched: got %0d expected %0d", mul_in_a, a); end
    rst = 1;
    step();
    rst = 0;
    mul_out_valid = 1; mul_out_result = RW'($urandom_range(1, 255));
    r0 = n_rsp;
    step();
    n_checks++;
    if (s_all !== 64'd0) begin n_fail++; $display("FAIL rstwait_outputs: got %h expected 0", s_all); end
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (n_rsp != r0) begin n_fail++; $display("FAIL rstwait_late_done: got %0d responses expected 0", n_rsp - r0); end
  endtask

  task automatic test_random();
    bit v[2];
    logic [WIDTH-1:0] ra[2], rb[2];
    int qid[$];
    logic [RW-1:0] qprod[$];
    bit busy, exp_grant, exp_err;
    int w, eid, r0, budget;
    logic [RW-1:0] eprod;
    do_reset();
    busy = 0; overlap = 0;
    for (int i = 0; i < 2; i++) begin v[i] = 0; ra[i] = '0; rb[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1; ra[i] = WIDTH'($urandom); rb[i] = WIDTH'($urandom);
        end
      end
      req0_valid = v[0]; req0_a = ra[0]; req0_b = rb[0];
      req1_valid = v[1]; req1_a = ra[1]; req1_b = rb[1];
      mul_lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      r0 = n_rsp;
      step();
      if (n_rsp != r0) begin
        n_checks++;
        if (qid.size() == 0) begin
          n_fail++; $display("FAIL rand_unexpected_rsp: got id=%0d expected none", r_id);
        end else begin
          eid = qid.pop_front(); eprod = qprod.pop_front();
          exp_err = (arm_lat == 0);
          if (r_id !== eid[0] || r_err !== exp_err || r_res !== (exp_err ? RW'(0) : eprod)) begin
            n_fail++; $display("FAIL rand_rsp: got id=%0d err=%0d res=%0d expected id=%0d err=%0d res=%0d",
                               r_id, r_err, r_res, eid, exp_err, exp_err ? 0 : eprod);
          end
          rr_m = 1 - eid; busy = 0;
        end
      end
      exp_grant = !busy && (v[0] || v[1]);
      w = v[rr_m] ? rr_m : 1 - rr_m;
      n_checks++;
      if (s_r0 !== (exp_grant && w == 0) || s_r1 !== (exp_grant && w == 1)) begin
        n_fail++; $display("FAIL rand_grant: got r0=%0d r1=%0d expected r0=%0d r1=%0d",
                           s_r0, s_r1, exp_grant && w == 0, exp_grant && w == 1);
      end
      if (exp_grant) begin
        qid.push_back(w); qprod.push_back(RW'(ra[w]) * RW'(rb[w]));
        busy = 1;
        v[w] = bit'($urandom_range(0, 1)); ra[w] = WIDTH'($urandom); rb[w] = WIDTH'($urandom);
      end
    end
    req0_valid = 0; req1_valid = 0; budget = 40;
    while (qid.size() != 0 && budget > 0) begin
      r0 = n_rsp;
      step();
      budget--;
      if (n_rsp != r0) begin void'(qid.pop_front()); void'(qprod.pop_front()); end
    end
    n_checks++;
    if (qid.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending expected 0", qid.size()); end
    n_checks++;
    if (overlap != 0) begin n_fail++; $display("FAIL rand_overlap: got %0d expected 0", overlap); end
  endtask

  initial begin
    rst = 1;
    req0_valid = 0; req0_valid_t = 0; req0_a = '0; req0_a_t = 0; req0_b = '0; req0_b_t = 0;
    req1_valid = 0; req1_valid_t = 0; req1_a = '0; req1_a_t = 0; req1_b = '0; req1_b_t = 0;
    mul_out_valid = 0; mul_out_valid_t = 0; mul_out_result = '0; mul_out_result_t = 0;
    taint_acc = 0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_boundary();
    test_taint();
    test_reset_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
